// File: rtl/device_status_poller.sv
// rtl/device_status_poller.sv - periodic multi-channel device status collector
// Walks each channel per poll, stores returned words in a status RAM, appends a summary word.
module device_status_poller #(
  parameter int NUM_CH = 5,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int CNT_W = 28,
  parameter int PERIOD = 20000000,
  parameter logic [NUM_CH*ADDR_W-1:0] CH_BASE = {9'd129, 9'd97, 9'd65, 9'd33, 9'd1},
  parameter logic [NUM_CH*8-1:0] CH_LEN = {8'd8, 8'd8, 8'd8, 8'd8, 8'd8},
  parameter int SEQ_ADDR = 0,
  parameter int TIMEOUT = 4095
) (
  input  logic                     spi_clk_in,
  input  logic                     spi_rst_in,
  input  logic                     dsp_rdy,
  input  logic                     force_poll,
  output logic [NUM_CH-1:0]        ch_rd_stat,
  output logic [NUM_CH-1:0]        ch_rd_en,
  input  logic [NUM_CH-1:0]        ch_rd_valid,
  input  logic [NUM_CH*DATA_W-1:0] ch_rd_data,
  input  logic                     mif_rd_stat,
  input  logic [ADDR_W-1:0]        mif_rd_addr,
  output logic [DATA_W-1:0]        mif_rd_data,
  output logic                     mif_rd_valid,
  output logic                     poll_busy,
  output logic                     poll_done,
  output logic [NUM_CH-1:0]        ch_timeout
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_NEXT, S_DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    timer;
  logic                tick;
  logic [CH_W-1:0]     ch;
  logic [7:0]          word_idx;
  logic [TO_W-1:0]     tcnt;
  logic [NUM_CH-1:0]   pend_to;
  logic [15:0]         seq_cnt;
  logic [7:0]          overrun;

  logic                wr_pend;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;

  logic [ADDR_W-1:0]   cur_base;
  logic [7:0]          cur_len;
  logic                cur_valid;
  logic [DATA_W-1:0]   cur_data;
  logic [7:0]          to8;
  logic [DATA_W-1:0]   summary;

  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W-1:0]   ram_q;
  logic [DATA_W-1:0]   mem [0:(2**ADDR_W)-1];

  logic                rd_stat_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic                rd_v1;

  function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] idx);
    logic [NUM_CH-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx == CH_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  assign cur_base  = CH_BASE[ch*ADDR_W +: ADDR_W];
  assign cur_len   = CH_LEN[ch*8 +: 8];
  assign cur_valid = ch_rd_valid[ch];
  assign cur_data  = ch_rd_data[ch*DATA_W +: DATA_W];

  always_comb begin
    to8 = '0;
    to8[NUM_CH-1:0] = pend_to;
  end

  always_comb begin
    summary = '0;
    summary[15:0]  = seq_cnt;
    summary[23:16] = to8;
    summary[31:24] = overrun;
  end

  // Period timer; dropping dsp_rdy restarts the full interval.
  always_ff @(posedge spi_clk_in or posedge spi_rst_in) begin
    if (spi_rst_in) begin
      timer <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (!dsp_rdy) begin
        timer <= '0;
      end else if (timer == CNT_W'(PERIOD - 1)) begin
        timer <= '0;
        tick  <= 1'b1;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

  always_ff @(posedge spi_clk_in or posedge spi_rst_in) begin
    if (spi_rst_in) begin
      state      <= S_IDLE;
      ch         <= '0;
      word_idx   <= '0;
      tcnt       <= '0;
      pend_to    <= '0;
      seq_cnt    <= '0;
      overrun    <= '0;
      ch_rd_stat <= '0;
      ch_rd_en   <= '0;
      poll_busy  <= 1'b0;
      poll_done  <= 1'b0;
      ch_timeout <= '0;
      wr_pend    <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      ch_rd_stat <= '0;
      poll_done  <= 1'b0;
      wr_pend    <= 1'b0;
      if (tick && state != S_IDLE && overrun != 8'hff) overrun <= overrun + 8'd1;
      case (state)
        S_IDLE: begin
          if (tick || force_poll) begin
            state      <= S_START;
            ch         <= '0;
            poll_busy  <= 1'b1;
            ch_rd_stat <= onehot('0);
            ch_rd_en   <= onehot('0);
          end
        end
        S_START: begin
          word_idx <= '0;
          tcnt     <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (cur_valid) begin
            wr_pend  <= 1'b1;
            wr_addr  <= cur_base + ADDR_W'(word_idx);
            wr_data  <= cur_data;
            word_idx <= word_idx + 8'd1;
            tcnt     <= '0;
            if (word_idx == cur_len - 8'd1) begin
              state    <= S_NEXT;
              ch_rd_en <= '0;
            end
          end else if (tcnt == TO_W'(TIMEOUT - 1)) begin
            pend_to[ch] <= 1'b1;
            state       <= S_NEXT;
            ch_rd_en    <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_NEXT: begin
          if (ch == CH_W'(NUM_CH - 1)) begin
            state     <= S_DONE;
            poll_done <= 1'b1;
          end else begin
            ch         <= ch + 1'b1;
            state      <= S_START;
            ch_rd_stat <= onehot(ch + 1'b1);
            ch_rd_en   <= onehot(ch + 1'b1);
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          poll_busy  <= 1'b0;
          seq_cnt    <= seq_cnt + 16'd1;
          ch_timeout <= pend_to;
          pend_to    <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Data writes trail their strobe by a cycle, so they never coincide with DONE.
  always_comb begin
    ram_we    = wr_pend;
    ram_waddr = wr_addr;
    ram_wdata = wr_data;
    if (state == S_DONE) begin
      ram_we    = 1'b1;
      ram_waddr = ADDR_W'(SEQ_ADDR);
      ram_wdata = summary;
    end
  end

  always_ff @(posedge spi_clk_in) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_q <= mem[rd_addr_q];
  end

  always_ff @(posedge spi_clk_in or posedge spi_rst_in) begin
    if (spi_rst_in) begin
      rd_stat_q    <= 1'b0;
      rd_addr_q    <= '0;
      rd_v1        <= 1'b0;
      mif_rd_valid <= 1'b0;
      mif_rd_data  <= '0;
    end else begin
      rd_stat_q    <= mif_rd_stat;
      rd_addr_q    <= mif_rd_addr;
      rd_v1        <= rd_stat_q;
      mif_rd_valid <= rd_v1;
      if (rd_v1) mif_rd_data <= ram_q;
    end
  end

endmodule

// File: tb/tb_device_status_poller.sv
// tb/tb_device_status_poller.sv - directed/randomised bench for device_status_poller
// Reference RAM image and summary counters are tracked in plain arrays and ints.
module tb_device_status_poller;
  localparam int NUM_CH = 2;
  localparam int ADDR_W = 9;
  localparam int PERIOD = 40;
  localparam int TIMEOUT = 20;
  localparam int BASE [2] = '{1, 10};
  localparam int LEN [2] = '{3, 2};

  logic        clk = 1'b0;
  logic        rst;
  logic        dsp_rdy;
  logic        force_poll;
  logic [1:0]  ch_rd_stat;
  logic [1:0]  ch_rd_en;
  logic [1:0]  ch_rd_valid;
  logic [63:0] ch_rd_data;
  logic        mif_rd_stat;
  logic [8:0]  mif_rd_addr;
  logic [31:0] mif_rd_data;
  logic        mif_rd_valid;
  logic        poll_busy;
  logic        poll_done;
  logic [1:0]  ch_timeout;

  int tests = 0;
  int fails = 0;
  logic [31:0] model_ram [0:511];
  bit          known [0:511];
  int seq_m = 0;
  int ovr_m = 0;
  int done_cnt = 0;
  int stat0_cnt = 0;
  int dbefore;
  int s0before;
  int n;
  logic [31:0] rd;

  device_status_poller #(
    .NUM_CH(2), .DATA_W(32), .ADDR_W(9), .CNT_W(28), .PERIOD(PERIOD),
    .CH_BASE({9'd10, 9'd1}), .CH_LEN({8'd2, 8'd3}), .SEQ_ADDR(0), .TIMEOUT(TIMEOUT)
  ) dut (
    .spi_clk_in(clk), .spi_rst_in(rst), .dsp_rdy(dsp_rdy), .force_poll(force_poll),
    .ch_rd_stat(ch_rd_stat), .ch_rd_en(ch_rd_en), .ch_rd_valid(ch_rd_valid),
    .ch_rd_data(ch_rd_data), .mif_rd_stat(mif_rd_stat), .mif_rd_addr(mif_rd_addr),
    .mif_rd_data(mif_rd_data), .mif_rd_valid(mif_rd_valid), .poll_busy(poll_busy),
    .poll_done(poll_done), .ch_timeout(ch_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (poll_done) done_cnt++;
    if (ch_rd_stat[0]) stat0_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic mif_read(input int addr, output logic [31:0] d);
    mif_rd_stat = 1'b1;
    mif_rd_addr = 9'(addr);
    @(negedge clk);
    mif_rd_stat = 1'b0;
    check("rd_lat1", 64'(mif_rd_valid), 64'(0));
    @(negedge clk);
    check("rd_lat2", 64'(mif_rd_valid), 64'(0));
    @(negedge clk);
    check("rd_valid", 64'(mif_rd_valid), 64'(1));
    d = mif_rd_data;
    @(negedge clk);
    check("rd_drop", 64'(mif_rd_valid), 64'(0));
    check("rd_hold", 64'(mif_rd_data), 64'(d));
  endtask

  task automatic check_ram(input int a);
    logic [31:0] d;
    mif_read(a, d);
    if (known[a]) check($sformatf("ram[%0d]", a), 64'(d), 64'(model_ram[a]));
  endtask

  task automatic check_all_ram();
    int addrs [6] = '{0, 1, 2, 3, 10, 11};
    foreach (addrs[i]) check_ram(addrs[i]);
  endtask

  task automatic wait_stat(input int ch);
    int k = 0;
    while (!ch_rd_stat[ch] && k < 300) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("start_ch%0d", ch), 64'(ch_rd_stat[ch]), 64'(1));
  endtask

  task automatic start_poll();
    dbefore = done_cnt;
    force_poll = 1'b1;
    @(negedge clk);
    force_poll = 1'b0;
    check("force_busy", 64'(poll_busy), 64'(1));
  endtask

  // Emulates one device: strobes nwords words after random gaps, optionally
  // strobing the other channels in the gaps and probing a read of the last word.
  task automatic do_channel(input int ch, input int nwords, input int gmin, input int gmax,
                            input bit noise, input bit probe);
    int gap, a;
    logic [31:0] d, old;
    logic [1:0] other;
    bit oldk;
    old = '0;
    oldk = 1'b0;
    other = 2'b11;
    other[ch] = 1'b0;
    wait_stat(ch);
    @(negedge clk);
    for (int k = 0; k < nwords; k++) begin
      gap = int'($urandom_range(gmax, gmin));
      for (int g = 0; g < gap; g++) begin
        if (noise) begin
          ch_rd_valid = other;
          ch_rd_data = {$urandom, $urandom};
        end
        @(negedge clk);
      end
      ch_rd_valid = '0;
      d = $urandom;
      a = (BASE[ch] + k) % 512;
      ch_rd_data[ch*32 +: 32] = d;
      ch_rd_valid[ch] = 1'b1;
      if (probe && k == nwords - 1) begin
        mif_rd_stat = 1'b1;
        mif_rd_addr = 9'(a);
        old = model_ram[a];
        oldk = known[a];
      end
      model_ram[a] = d;
      known[a] = 1'b1;
      @(negedge clk);
      ch_rd_valid = '0;
      mif_rd_stat = 1'b0;
    end
    if (probe) begin
      @(negedge clk);
      @(negedge clk);
      check("probe_valid", 64'(mif_rd_valid), 64'(1));
      if (oldk) check("read_first", 64'(mif_rd_data), 64'(old));
    end
  endtask

  task automatic finish_poll(input logic [1:0] exp_to);
    int k = 0;
    while (done_cnt == dbefore && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("poll_done_seen", 64'(done_cnt), 64'(dbefore + 1));
    model_ram[0] = {8'(ovr_m), 6'b0, exp_to, 16'(seq_m)};
    known[0] = 1'b1;
    seq_m = (seq_m + 1) % 65536;
    @(negedge clk);
    check("ch_timeout", 64'(ch_timeout), 64'(exp_to));
    check("busy_clear", 64'(poll_busy), 64'(0));
    check_ram(0);
  endtask

  initial begin
    rst = 1'b1;
    dsp_rdy = 1'b0;
    force_poll = 1'b0;
    ch_rd_valid = '0;
    ch_rd_data = '0;
    mif_rd_stat = 1'b0;
    mif_rd_addr = '0;
    foreach (known[i]) known[i] = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_stat", 64'(ch_rd_stat), 64'(0));
    check("rst_en", 64'(ch_rd_en), 64'(0));
    check("rst_rdata", 64'(mif_rd_data), 64'(0));
    check("rst_rvalid", 64'(mif_rd_valid), 64'(0));
    check("rst_busy", 64'(poll_busy), 64'(0));
    check("rst_done", 64'(poll_done), 64'(0));
    check("rst_to", 64'(ch_timeout), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Two normal polls; summary sequence numbers 0 then 1.
    for (int p = 0; p < 2; p++) begin
      start_poll();
      do_channel(0, LEN[0], 0, 4, 1'b0, 1'b0);
      do_channel(1, LEN[1], 0, 4, 1'b0, 1'b0);
      finish_poll(2'b00);
      check_all_ram();
    end

    // Channel 1 silent: enable stays up for START plus TIMEOUT wait cycles.
    start_poll();
    do_channel(0, LEN[0], 0, 4, 1'b0, 1'b0);
    wait_stat(1);
    n = 1;
    @(negedge clk);
    while (ch_rd_en[1] && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("timeout_len", 64'(n), 64'(TIMEOUT + 1));
    finish_poll(2'b10);
    check_all_ram();

    // Reset in the middle of channel 0 aborts the poll and clears counters.
    start_poll();
    do_channel(0, 1, 0, 2, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    dbefore = done_cnt;
    rst = 1'b1;
    #1;
    check("mid_rst_stat", 64'(ch_rd_stat), 64'(0));
    check("mid_rst_en", 64'(ch_rd_en), 64'(0));
    check("mid_rst_rdata", 64'(mif_rd_data), 64'(0));
    check("mid_rst_busy", 64'(poll_busy), 64'(0));
    check("mid_rst_to", 64'(ch_timeout), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seq_m = 0;
    ovr_m = 0;
    repeat (40) @(negedge clk);
    check("no_done_after_rst", 64'(done_cnt), 64'(dbefore));
    check("idle_after_rst", 64'(poll_busy), 64'(0));
    check_ram(1);

    // Stray strobes in IDLE and from channel 0 during channel 1 are ignored.
    for (int i = 0; i < 5; i++) begin
      ch_rd_valid = 2'b11;
      ch_rd_data = {$urandom, $urandom};
      @(negedge clk);
    end
    ch_rd_valid = '0;
    check("idle_strobe_busy", 64'(poll_busy), 64'(0));
    start_poll();
    do_channel(0, LEN[0], 0, 3, 1'b0, 1'b0);
    do_channel(1, LEN[1], 1, 4, 1'b1, 1'b1);
    finish_poll(2'b00);
    check_all_ram();

    // Timer: partial count then drop restarts the full period.
    s0before = stat0_cnt;
    dsp_rdy = 1'b1;
    repeat (25) @(negedge clk);
    check("no_early_tick", 64'(poll_busy), 64'(0));
    dsp_rdy = 1'b0;
    repeat (10) @(negedge clk);
    dbefore = done_cnt;
    dsp_rdy = 1'b1;
    n = 0;
    while (!poll_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("tick_period", 64'(n), 64'(PERIOD + 1));

    // Slow device keeps the poll busy across the next two ticks.
    do_channel(0, LEN[0], 18, 18, 1'b0, 1'b0);
    do_channel(1, LEN[1], 18, 18, 1'b0, 1'b0);
    n = 0;
    while (done_cnt == dbefore && n < 100) begin
      @(negedge clk);
      n++;
    end
    dsp_rdy = 1'b0;
    ovr_m = 2;
    finish_poll(2'b00);
    repeat (5) @(negedge clk);
    check("single_start", 64'(stat0_cnt), 64'(s0before + 1));
    check("single_done", 64'(done_cnt), 64'(dbefore + 1));
    check_all_ram();

    // Final random poll with channel 0 cut short.
    start_poll();
    do_channel(0, 2, 0, 5, 1'b0, 1'b0);
    do_channel(1, LEN[1], 0, 5, 1'b0, 1'b0);
    finish_poll(2'b01);
    check_all_ram();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
